// File: rtl/bp_mem_beat_bridge.sv
// Serializes one block-wide memory command into 64-bit beat transactions
// (critical word first) and gathers read beats into a single response.
module bp_mem_beat_bridge #(
  parameter int paddr_width_p   = 40,
  parameter int block_width_p   = 512,
  parameter int payload_width_p = 16,
  localparam int mem_msg_width_lp = 4 + paddr_width_p + 3 + payload_width_p + block_width_p
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [mem_msg_width_lp-1:0] mem_cmd_i,
  input  logic                        mem_cmd_v_i,
  output logic                        mem_cmd_ready_o,
  output logic [mem_msg_width_lp-1:0] mem_resp_o,
  output logic                        mem_resp_v_o,
  input  logic                        mem_resp_yumi_i,
  output logic                        beat_v_o,
  input  logic                        beat_ready_i,
  output logic                        beat_w_o,
  output logic [paddr_width_p-1:0]    beat_addr_o,
  output logic [63:0]                 beat_wdata_o,
  output logic [7:0]                  beat_wmask_o,
  input  logic [63:0]                 beat_rdata_i,
  input  logic                        beat_rdata_v_i,
  output logic                        error_o
);

  localparam int hdr_width_lp = 4 + paddr_width_p + 3 + payload_width_p;
  localparam int lanes_lp     = block_width_p / 64;
  localparam logic [2:0] max_size_lp = 3'($clog2(block_width_p / 8));

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

  state_e                      state_r;
  logic                        ready_r;
  logic [mem_msg_width_lp-1:0] cmd_r;
  logic [block_width_p-1:0]    resp_data_r;
  logic                        resp_v_r;
  logic [3:0]                  n_r;
  logic                        is_w_r;
  logic [3:0]                  issue_cnt_r;
  logic [3:0]                  rcv_cnt_r;
  logic                        beat_v_r;
  logic                        beat_w_r;
  logic [paddr_width_p-1:0]    beat_addr_r;
  logic [63:0]                 beat_wdata_r;
  logic [7:0]                  beat_wmask_r;
  logic                        error_r;

  logic [3:0]               cur_type;
  logic [paddr_width_p-1:0] cur_addr;
  logic [2:0]               cur_size_raw;
  logic [2:0]               cur_size;
  logic [2:0]               align_lg;
  logic [block_width_p-1:0] cur_data;
  logic [3:0]               cur_n;
  logic [3:0]               cur_idx;
  logic [3:0]               wrap_idx;
  logic                     cur_w;
  logic [7:0]               sub_mask;
  logic [paddr_width_p-1:0] nxt_addr;
  logic [63:0]              nxt_wdata;
  logic [7:0]               nxt_wmask;
  logic                     hs;
  logic                     last_hs;
  logic                     rd_acc;
  logic [3:0]               rcv_next;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Beat fields for the next beat: from the incoming command while idle, else from the captured one
  always_comb begin
    if (state_r == ST_IDLE) begin
      cur_type     = mem_cmd_i[3:0];
      cur_addr     = mem_cmd_i[4 +: paddr_width_p];
      cur_size_raw = mem_cmd_i[4+paddr_width_p +: 3];
      cur_data     = mem_cmd_i[hdr_width_lp +: block_width_p];
      cur_idx      = 4'd0;
    end else begin
      cur_type     = cmd_r[3:0];
      cur_addr     = cmd_r[4 +: paddr_width_p];
      cur_size_raw = cmd_r[4+paddr_width_p +: 3];
      cur_data     = cmd_r[hdr_width_lp +: block_width_p];
      cur_idx      = issue_cnt_r + 4'd1;
    end
    cur_size = (cur_size_raw > max_size_lp) ? max_size_lp : cur_size_raw;
    cur_w    = (cur_type == 4'd2) || (cur_type == 4'd3);
    if (cur_size < 3'd3) begin
      cur_n    = 4'd1;
      align_lg = 3'd3;
    end else begin
      cur_n    = 4'd1 << (cur_size - 3'd3);
      align_lg = cur_size;
    end
    // Critical word first, wrapping inside the size-aligned region
    wrap_idx = (4'(cur_addr[5:3]) + cur_idx) & (cur_n - 4'd1);
    nxt_addr = (cur_addr & ~((paddr_width_p'(1) << align_lg) - paddr_width_p'(1)))
             + (paddr_width_p'(wrap_idx) << 3);
    case (cur_size)
      3'd0:    sub_mask = 8'h01;
      3'd1:    sub_mask = 8'h03;
      3'd2:    sub_mask = 8'h0F;
      default: sub_mask = 8'hFF;
    endcase
    if (!cur_w) begin
      nxt_wmask = 8'h00;
      nxt_wdata = 64'h0;
    end else if (cur_size < 3'd3) begin
      nxt_wmask = sub_mask << cur_addr[2:0];
      nxt_wdata = cur_data[63:0] << {cur_addr[2:0], 3'b000};
    end else begin
      nxt_wmask = 8'hFF;
      nxt_wdata = 64'(cur_data >> {cur_idx, 6'b000000});
    end
  end

  assign hs       = beat_v_r && beat_ready_i;
  assign last_hs  = hs && ((issue_cnt_r + 4'd1) == n_r);
  assign rd_acc   = beat_rdata_v_i && !is_w_r && (rcv_cnt_r < n_r)
                 && ((state_r == ST_ISSUE) || (state_r == ST_WAIT));
  assign rcv_next = rd_acc ? sat_inc(rcv_cnt_r) : rcv_cnt_r;

  // Control FSM, beat issue registers and read-data collection
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= ST_IDLE;
      ready_r      <= 1'b0;
      cmd_r        <= '0;
      resp_data_r  <= '0;
      resp_v_r     <= 1'b0;
      n_r          <= 4'd0;
      is_w_r       <= 1'b0;
      issue_cnt_r  <= 4'd0;
      rcv_cnt_r    <= 4'd0;
      beat_v_r     <= 1'b0;
      beat_w_r     <= 1'b0;
      beat_addr_r  <= '0;
      beat_wdata_r <= 64'h0;
      beat_wmask_r <= 8'h00;
      error_r      <= 1'b0;
    end else begin
      if (beat_rdata_v_i && !rd_acc) error_r <= 1'b1;
      if (rd_acc) begin
        for (int k = 0; k < lanes_lp; k++) begin
          if (rcv_cnt_r == 4'(k)) resp_data_r[k*64 +: 64] <= beat_rdata_i;
        end
        rcv_cnt_r <= rcv_next;
      end
      case (state_r)
        ST_IDLE: begin
          if (ready_r && mem_cmd_v_i) begin
            ready_r      <= 1'b0;
            cmd_r        <= mem_cmd_i;
            resp_data_r  <= '0;
            n_r          <= cur_n;
            is_w_r       <= cur_w;
            issue_cnt_r  <= 4'd0;
            rcv_cnt_r    <= 4'd0;
            beat_v_r     <= 1'b1;
            beat_w_r     <= cur_w;
            beat_addr_r  <= nxt_addr;
            beat_wdata_r <= nxt_wdata;
            beat_wmask_r <= nxt_wmask;
            state_r      <= ST_ISSUE;
          end else begin
            ready_r <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (hs) begin
            issue_cnt_r <= sat_inc(issue_cnt_r);
            if (last_hs) begin
              beat_v_r <= 1'b0;
              // A read's final beat may come back in the same cycle as its issue
              if (is_w_r || (rcv_next == n_r)) begin
                resp_v_r <= 1'b1;
                state_r  <= ST_RESP;
              end else begin
                state_r  <= ST_WAIT;
              end
            end else begin
              beat_addr_r  <= nxt_addr;
              beat_wdata_r <= nxt_wdata;
              beat_wmask_r <= nxt_wmask;
            end
          end
        end
        ST_WAIT: begin
          if (rd_acc && (rcv_next == n_r)) begin
            resp_v_r <= 1'b1;
            state_r  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (mem_resp_yumi_i) begin
            resp_v_r <= 1'b0;
            ready_r  <= 1'b1;
            state_r  <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign mem_cmd_ready_o = ready_r;
  assign mem_resp_o      = {resp_data_r, cmd_r[hdr_width_lp-1:0]};
  assign mem_resp_v_o    = resp_v_r;
  assign beat_v_o        = beat_v_r;
  assign beat_w_o        = beat_w_r;
  assign beat_addr_o     = beat_addr_r;
  assign beat_wdata_o    = beat_wdata_r;
  assign beat_wmask_o    = beat_wmask_r;
  assign error_o         = error_r;

endmodule
